controller: RTL and testbench

Multicycle sequencer for the 8-bit stack-machine datapath. Takes the 3-bit opcode from the instruction register and drives every datapath control line. It steps each instruction through fetch, decode and a per-opcode execute sequence, then returns to fetch. It sits beside the datapath in the CPU top level and is its only source of control.

---
 rtl/controller.sv | 155 +++++++++++++++
 tb/tb_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module  : controller
// Brief   : Moore-style multicycle sequencer for the 8-bit stack-machine CPU.
// Revision: 1.0 - initial release
// ============================================================================
module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opc,
    output logic [1:0] ALUOP,
    output logic       pcWriteUnCond,
    output logic       pcWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       pcSrc,
    output logic       done
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        POPA    = 4'd2,
        POPB    = 4'd3,
        EXEC    = 4'd4,
        PUSHRES = 4'd5,
        MEMRD   = 4'd6,
        PUSHMEM = 4'd7,
        MEMWR   = 4'd8,
        JUMP    = 4'd9,
        BRZ     = 4'd10
    } state_e;

    // Plain vector so encodings 11-15 remain representable and recoverable.
    logic [3:0] r_state;
    state_e     w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (opc)
                    3'b100:  w_next = MEMRD;
                    3'b110:  w_next = JUMP;
                    3'b111:  w_next = BRZ;
                    default: w_next = POPA;
                endcase
            end
            POPA: begin
                case (opc)
                    3'b000, 3'b001, 3'b010: w_next = POPB;
                    3'b011:                 w_next = EXEC;
                    3'b101:                 w_next = MEMWR;
                    default:                w_next = FETCH;
                endcase
            end
            POPB:    w_next = EXEC;
            EXEC:    w_next = PUSHRES;
            MEMRD:   w_next = PUSHMEM;
            default: w_next = FETCH;
        endcase
    end

    // Outputs are gated by rst so they drop immediately when reset asserts.
    always_comb begin
        ALUOP         = 2'b00;
        pcWriteUnCond = 1'b0;
        pcWriteCond   = 1'b0;
        IorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        IRWrite       = 1'b0;
        MtoS          = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        tos           = 1'b0;
        ldA           = 1'b0;
        ldB           = 1'b0;
        srcA          = 1'b0;
        srcB          = 1'b0;
        pcSrc         = 1'b0;
        done          = 1'b0;
        if (rst) begin
            case (r_state)
                FETCH: begin
                    memRead       = 1'b1;
                    IRWrite       = 1'b1;
                    srcA          = 1'b1;
                    srcB          = 1'b1;
                    pcWriteUnCond = 1'b1;
                end
                DECODE: tos = 1'b1;
                POPA: begin
                    pop = 1'b1;
                    ldA = 1'b1;
                end
                POPB: begin
                    pop = 1'b1;
                    ldB = 1'b1;
                end
                EXEC: ALUOP = opc[1:0];
                PUSHRES: begin
                    push = 1'b1;
                    done = 1'b1;
                end
                MEMRD: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                end
                PUSHMEM: begin
                    MtoS = 1'b1;
                    push = 1'b1;
                    done = 1'b1;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                    done     = 1'b1;
                end
                JUMP: begin
                    pcSrc         = 1'b1;
                    pcWriteUnCond = 1'b1;
                    done          = 1'b1;
                end
                BRZ: begin
                    pcSrc       = 1'b1;
                    pcWriteCond = 1'b1;
                    done        = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_controller
// Brief   : Self-checking bench for the stack-machine controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opc;
    logic [1:0] ALUOP;
    logic       pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite;
    logic       MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, done;

    controller dut (
        .clk(clk), .rst(rst), .opc(opc), .ALUOP(ALUOP),
        .pcWriteUnCond(pcWriteUnCond), .pcWriteCond(pcWriteCond),
        .IorD(IorD), .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
        .MtoS(MtoS), .push(push), .pop(pop), .tos(tos), .ldA(ldA), .ldB(ldB),
        .srcA(srcA), .srcB(srcB), .pcSrc(pcSrc), .done(done)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {ALUOP, pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite,
                   IRWrite, MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, done};

    localparam logic [17:0] c_done = 18'h1 << 0;
    localparam logic [17:0] c_pcsrc = 18'h1 << 1;
    localparam logic [17:0] c_srcb = 18'h1 << 2;
    localparam logic [17:0] c_srca = 18'h1 << 3;
    localparam logic [17:0] c_ldb = 18'h1 << 4;
    localparam logic [17:0] c_lda = 18'h1 << 5;
    localparam logic [17:0] c_tos = 18'h1 << 6;
    localparam logic [17:0] c_pop = 18'h1 << 7;
    localparam logic [17:0] c_push = 18'h1 << 8;
    localparam logic [17:0] c_mtos = 18'h1 << 9;
    localparam logic [17:0] c_irw = 18'h1 << 10;
    localparam logic [17:0] c_memwr = 18'h1 << 11;
    localparam logic [17:0] c_memrd = 18'h1 << 12;
    localparam logic [17:0] c_iord = 18'h1 << 13;
    localparam logic [17:0] c_pcc = 18'h1 << 14;
    localparam logic [17:0] c_pcu = 18'h1 << 15;
    localparam logic [17:0] c_fetch = c_memrd | c_irw | c_srca | c_srcb | c_pcu;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [2:0]  opc;
        int          len;
        logic [17:0] last;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: the micro-action recipe of each instruction, one entry per cycle.
    task automatic build_expected(input logic [2:0] o);
        exp_q.delete();
        exp_q.push_back(c_fetch);
        exp_q.push_back(c_tos);
        case (o)
            3'd4: begin
                exp_q.push_back(c_iord | c_memrd);
                exp_q.push_back(c_mtos | c_push | c_done);
            end
            3'd5: begin
                exp_q.push_back(c_pop | c_lda);
                exp_q.push_back(c_iord | c_memwr | c_done);
            end
            3'd6: exp_q.push_back(c_pcsrc | c_pcu | c_done);
            3'd7: exp_q.push_back(c_pcsrc | c_pcc | c_done);
            default: begin
                exp_q.push_back(c_pop | c_lda);
                if (o != 3'd3) exp_q.push_back(c_pop | c_ldb);
                exp_q.push_back({o[1:0], 16'h0});
                exp_q.push_back(c_push | c_done);
            end
        endcase
    endtask

    // Entered just after a negedge while the DUT shows FETCH; leaves at the next FETCH.
    task automatic run_instr(input logic [2:0] o, input bit use_model,
                             output int ncyc, output logic [17:0] last);
        logic       got;
        logic [17:0] viol;
        opc  = o;
        build_expected(o);
        ncyc = 0;
        last = '0;
        got  = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            ncyc++;
            if (use_model) begin
                if (c < exp_q.size()) check($sformatf("model op%0d cyc%0d", o, c), outs, exp_q[c]);
                else check($sformatf("overrun op%0d", o), outs, 18'h0);
            end
            viol = {14'h0, push & pop, memRead & memWrite, pcWriteUnCond & pcWriteCond, ldA & ldB};
            check("exclusive", viol, 18'h0);
            if (done) begin
                got  = 1'b1;
                last = outs;
                n_done++;
            end
            @(negedge clk);
        end
        if (!got) check($sformatf("timeout op%0d", o), 18'h0, c_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ncyc;
        logic [17:0] last;
        logic [2:0]  ro;

        tbl[0] = '{3'd0, 6, c_push | c_done};
        tbl[1] = '{3'd1, 6, c_push | c_done};
        tbl[2] = '{3'd2, 6, c_push | c_done};
        tbl[3] = '{3'd3, 5, c_push | c_done};
        tbl[4] = '{3'd4, 4, c_mtos | c_push | c_done};
        tbl[5] = '{3'd5, 4, c_iord | c_memwr | c_done};
        tbl[6] = '{3'd6, 3, c_pcsrc | c_pcu | c_done};
        tbl[7] = '{3'd7, 3, c_pcsrc | c_pcc | c_done};

        rst = 1'b0;
        opc = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset outputs", outs, 18'h0);
        end
        rst = 1'b1;
        #1;
        check("first fetch", outs, c_fetch);

        foreach (tbl[i]) begin
            run_instr(tbl[i].opc, 1'b0, ncyc, last);
            check($sformatf("latency op%0d", tbl[i].opc), 18'(ncyc), 18'(tbl[i].len));
            check($sformatf("done pattern op%0d", tbl[i].opc), last, tbl[i].last);
        end

        // Illegal encoding: zero outputs, then FETCH on the following edge.
        force dut.r_state = 4'd12;
        #1;
        check("illegal state outputs", outs, 18'h0);
        release dut.r_state;
        @(negedge clk);
        check("illegal recovers to fetch", outs, c_fetch);

        // Reset asserted during EXEC of SUB drops outputs before the next edge.
        opc = 3'b001;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("sub exec", outs, {2'b01, 16'h0});
        #2 rst = 1'b0;
        #1;
        check("async reset in exec", outs, 18'h0);
        @(negedge clk);
        check("held reset", outs, 18'h0);
        rst = 1'b1;
        #1;
        check("fetch after reset", outs, c_fetch);

        n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            ro = 3'($urandom_range(0, 7));
            run_instr(ro, 1'b1, ncyc, last);
        end
        check("done count", 18'(n_done), 18'd1000);
        check("fetch after stream", outs, c_fetch);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
